// File: rtl/mult_div_unit.sv
// Sequential signed 32-bit multiply/divide unit: shift-add mult, restoring div.
// Optional MDU_UNSIGNED_EN enables op[1] = multu/divu (no sign fix-up).
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic               r_div;
  logic               r_negq;
  logic               r_negr;
  logic               r_dz;

  logic               w_uns;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH+1:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

`ifdef MDU_UNSIGNED_EN
  assign w_uns = op[1];
`else
  logic w_unused_op1;
  assign w_unused_op1 = op[1];
  assign w_uns = 1'b0;
`endif

  // Operand magnitudes and one datapath step for each operation
  always_comb begin
    w_sa    = a[WIDTH-1] & ~w_uns;
    w_sb    = b[WIDTH-1] & ~w_uns;
    w_abs_a = w_sa ? -a : a;
    w_abs_b = w_sb ? -b : b;
    w_msum  = {1'b0, r_acc} +
              {1'b0, (r_q[0] ? r_mcand : '0)};
    w_rsh   = {r_acc, r_q[WIDTH-1]};
    w_diff  = {1'b0, w_rsh} - {2'b00, r_mcand};
    w_prod  = {r_acc, r_q};
    w_prod_fix = r_negq ? -w_prod : w_prod;
    w_quot_fix = r_negq ? -r_q : r_q;
    w_rem_fix  = r_negr ? -r_acc : r_acc;
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_div    <= 1'b0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_dz     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy   <= 1'b1;
            r_cnt  <= CNT_W'(WIDTH);
            r_div  <= op[0];
            r_acc  <= '0;
            r_negq <= w_sa ^ w_sb;
            r_negr <= w_sa;
            r_mcand <= op[0] ? w_abs_b : w_abs_a;
            r_q     <= op[0] ? w_abs_a : w_abs_b;
            if (op[0] && (b == '0)) begin
              div_zero <= 1'b1;
              r_dz     <= 1'b1;
              r_state  <= S_FIX;
            end else begin
              div_zero <= 1'b0;
              r_dz     <= 1'b0;
              r_state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (!r_div) begin
            r_acc <= w_msum[WIDTH:1];
            r_q   <= {w_msum[0], r_q[WIDTH-1:1]};
          end else if (!w_diff[WIDTH+1]) begin
            r_acc <= w_diff[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_acc <= w_rsh[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b0};
          end
          if (r_cnt == CNT_W'(1))
            r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_dz) begin
            if (r_div) begin
              hi <= w_rem_fix;
              lo <= w_quot_fix;
            end else begin
              hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              lo <= w_prod_fix[WIDTH-1:0];
            end
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Define MDU_UNSIGNED_EN for both files to exercise multu.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_checks;
  int n_fail;

  mult_div_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .hi(hi),
    .lo(lo),
    .busy(busy),
    .done(done),
    .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [1:0] o,
                             input logic [31:0] x,
                             input logic [31:0] y);
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Starts an op, returns cycles from the start edge until done is seen.
  task automatic run_op(input string tag,
                        input logic [1:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        output int lat);
    pulse_start(o, x, y);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    a   = 32'hDEAD_BEEF;
    b   = 32'h1234_5678;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;
  int pulses;
  logic [31:0] lo_at_done;
  logic [31:0] hi_at_done;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op("m7x-3", 2'b00, 32'd7, 32'hFFFF_FFFD, lat);
    check("m7x-3_lat", 64'(lat), 64'd33);
    check("m7x-3_hi", 64'(hi), 64'hFFFF_FFFF);
    check("m7x-3_lo", 64'(lo), 64'hFFFF_FFEB);
    check("m7x-3_busy_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("m7x-3_pulse", 64'(done), 64'd0);

    run_op("d-7/2", 2'b01, 32'hFFFF_FFF9, 32'd2, lat);
    check("d-7/2_lat", 64'(lat), 64'd33);
    check("d-7/2_lo", 64'(lo), 64'hFFFF_FFFD);
    check("d-7/2_hi", 64'(hi), 64'hFFFF_FFFF);
    check("d-7/2_dz", 64'(div_zero), 64'd0);

    run_op("d5/0", 2'b01, 32'd5, 32'd0, lat);
    check("d5/0_lat", 64'(lat), 64'd1);
    check("d5/0_dz", 64'(div_zero), 64'd1);
    check("d5/0_hi", 64'(hi), 64'hFFFF_FFFF);
    check("d5/0_lo", 64'(lo), 64'hFFFF_FFFD);
    @(negedge clk);
    check("d5/0_pulse", 64'(done), 64'd0);

    run_op("m2x3", 2'b00, 32'd2, 32'd3, lat);
    check("m2x3_lo", 64'(lo), 64'd6);
    check("m2x3_hi", 64'(hi), 64'd0);
    check("m2x3_dz", 64'(div_zero), 64'd0);

    run_op("ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("ovf_lo", 64'(lo), 64'h8000_0000);
    check("ovf_hi", 64'(hi), 64'd0);
    check("ovf_dz", 64'(div_zero), 64'd0);

    run_op("d100/-7", 2'b01, 32'd100, 32'hFFFF_FFF9, lat);
    check("d100/-7_lo", 64'(lo), 64'hFFFF_FFF2);
    check("d100/-7_hi", 64'(hi), 64'd2);

    run_op("m-5x-6", 2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, lat);
    check("m-5x-6_lo", 64'(lo), 64'd30);
    check("m-5x-6_hi", 64'(hi), 64'd0);

    // second start while busy must be ignored
    pulse_start(2'b00, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    a     = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    lo_at_done = '0;
    hi_at_done = '1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        pulses++;
        lo_at_done = lo;
        hi_at_done = hi;
      end
      @(negedge clk);
    end
    check("busy_pulses", 64'(pulses), 64'd1);
    check("busy_lo", 64'(lo_at_done), 64'd12);
    check("busy_hi", 64'(hi_at_done), 64'd0);

    // asynchronous reset in the middle of an operation
    pulse_start(2'b00, 32'd5, 32'd6);
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op("mu", 2'b10, 32'hFFFF_FFFF, 32'd2, lat);
    check("mu_lat", 64'(lat), 64'd33);
`ifdef MDU_UNSIGNED_EN
    check("mu_hi", 64'(hi), 64'd1);
    check("mu_lo", 64'(lo), 64'hFFFF_FFFE);
`else
    check("mu_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mu_lo", 64'(lo), 64'hFFFF_FFFE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
